// File: rtl/wbit_alu_arbiter_2305001_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : wbit_alu_arbiter_2305001_pkg                              |
// | Purpose  : State encoding and ALU control codes for the ALU arbiter. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package wbit_alu_arbiter_2305001_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

endpackage

`default_nettype wire

// File: rtl/wbit_alu_arbiter_2305001_alu.sv
// +----------------------------------------------------------------------+
// | Module   : Wbit_ALU_2305001                                          |
// | Purpose  : W-bit combinational ALU, 8 ops, ARM-style NZCV flags.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module Wbit_ALU_2305001 #(
  parameter int W = 5
) (
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  input  logic [2:0]   ALU_Control,
  output logic [W-1:0] Result,
  output logic [3:0]   NZCV
);

  logic [W-1:0] w_sum;
  logic         w_carry;
  logic         w_ovf;

  // Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 signed SLT, 7 pass A.
  // C on SUB is "no borrow"; C and V are zero for non-arithmetic ops.
  always_comb begin
    w_sum   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    Result  = '0;
    case (ALU_Control)
      3'd0: begin
        {w_carry, w_sum} = {1'b0, InA} + {1'b0, InB};
        w_ovf  = (InA[W-1] == InB[W-1]) && (w_sum[W-1] != InA[W-1]);
        Result = w_sum;
      end
      3'd1: begin
        {w_carry, w_sum} = {1'b0, InA} + {1'b0, ~InB} + {{W{1'b0}}, 1'b1};
        w_ovf  = (InA[W-1] != InB[W-1]) && (w_sum[W-1] != InA[W-1]);
        Result = w_sum;
      end
      3'd2:    Result = InA & InB;
      3'd3:    Result = InA | InB;
      3'd4:    Result = InA ^ InB;
      3'd5:    Result = ~(InA | InB);
      3'd6:    Result = {{(W-1){1'b0}}, ($signed(InA) < $signed(InB))};
      default: Result = InA;
    endcase
    NZCV = {Result[W-1], (Result == '0), w_carry, w_ovf};
  end

endmodule

`default_nettype wire

// File: rtl/wbit_alu_arbiter_2305001_rr_pick2.sv
// +----------------------------------------------------------------------+
// | Module   : rr_pick2_2305001                                          |
// | Purpose  : Two-way round-robin pick; a tie goes to the non-last one. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick2_2305001 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

`default_nettype wire

// File: rtl/wbit_alu_arbiter_2305001.sv
// +----------------------------------------------------------------------+
// | Module   : wbit_alu_arbiter_2305001                                  |
// | Purpose  : Shares one ALU between two requesters (IDLE/EXEC/RESP).   |
// |            ALU_ARB_FASTPATH_EN: grant straight out of RESP.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module wbit_alu_arbiter_2305001
  import wbit_alu_arbiter_2305001_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         Req0,
  input  logic [W-1:0] InA0,
  input  logic [W-1:0] InB0,
  input  logic [2:0]   Ctl0,
  output logic         Ack0,
  input  logic         Req1,
  input  logic [W-1:0] InA1,
  input  logic [W-1:0] InB1,
  input  logic [2:0]   Ctl1,
  output logic         Ack1,
  output logic         Rsp_Valid,
  input  logic         Rsp_Ready,
  output logic         Rsp_Id,
  output logic [W-1:0] Rsp_Result,
  output logic [3:0]   Rsp_NZCV
);

  state_t       r_state;
  logic         r_last;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [2:0]   r_ctl;

  logic         w_gnt_valid;
  logic         w_gnt_id;
  logic         w_grant;
  logic [W-1:0] w_result;
  logic [3:0]   w_nzcv;

  rr_pick2_2305001 u_rr (
    .req0       (Req0),
    .req1       (Req1),
    .last_grant (r_last),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  Wbit_ALU_2305001 #(.W(W)) u_alu (
    .InA         (r_a),
    .InB         (r_b),
    .ALU_Control (r_ctl),
    .Result      (w_result),
    .NZCV        (w_nzcv)
  );

  // Ack is decoded in the granting cycle so a requester sees it while still
  // holding its operands; that is what gives Ack(t) -> Rsp_Valid(t+2).
`ifdef ALU_ARB_FASTPATH_EN
  assign w_grant = ~RESET & w_gnt_valid &
                   ((r_state == IDLE) | ((r_state == RESP) & Rsp_Ready));
`else
  assign w_grant = ~RESET & w_gnt_valid & (r_state == IDLE);
`endif

  assign Ack0 = w_grant & ~w_gnt_id;
  assign Ack1 = w_grant &  w_gnt_id;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_ctl      <= '0;
      Rsp_Valid  <= 1'b0;
      Rsp_Id     <= 1'b0;
      Rsp_Result <= '0;
      Rsp_NZCV   <= '0;
    end else begin
      if (w_grant) begin
        r_a    <= w_gnt_id ? InA1 : InA0;
        r_b    <= w_gnt_id ? InB1 : InB0;
        r_ctl  <= w_gnt_id ? Ctl1 : Ctl0;
        Rsp_Id <= w_gnt_id;
        r_last <= w_gnt_id;
      end
      case (r_state)
        IDLE: begin
          if (w_grant) r_state <= EXEC;
        end
        EXEC: begin
          Rsp_Result <= w_result;
          Rsp_NZCV   <= w_nzcv;
          Rsp_Valid  <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            r_state   <= w_grant ? EXEC : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wbit_alu_arbiter_2305001.sv
// +----------------------------------------------------------------------+
// | Module   : tb_wbit_alu_arbiter_2305001                               |
// | Purpose  : Directed self-checking bench for the ALU arbiter.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wbit_alu_arbiter_2305001;
  import wbit_alu_arbiter_2305001_pkg::*;

  localparam int W = 5;
`ifdef ALU_ARB_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Req0, Req1, Rsp_Ready;
  logic [W-1:0] InA0, InB0, InA1, InB1;
  logic [2:0]   Ctl0, Ctl1;
  logic         Ack0, Ack1, Rsp_Valid, Rsp_Id;
  logic [W-1:0] Rsp_Result;
  logic [3:0]   Rsp_NZCV;

  int checks = 0;
  int errors = 0;

  wbit_alu_arbiter_2305001 #(.W(W)) dut (
    .CLK(CLK), .RESET(RESET),
    .Req0(Req0), .InA0(InA0), .InB0(InB0), .Ctl0(Ctl0), .Ack0(Ack0),
    .Req1(Req1), .InA1(InA1), .InB1(InB1), .Ctl1(Ctl1), .Ack1(Ack1),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
    .Rsp_Result(Rsp_Result), .Rsp_NZCV(Rsp_NZCV)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Ticks until Rsp_Valid is seen at a falling edge; returns cycles waited.
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge CLK);
    while (!Rsp_Valid && n < 6) begin
      tick;
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; Req0 = 0; Req1 = 0; Rsp_Ready = 1'b1;
    InA0 = '0; InB0 = '0; Ctl0 = '0; InA1 = '0; InB1 = '0; Ctl1 = '0;
    @(negedge CLK); @(negedge CLK);
    checks++;
    if ({Ack0, Ack1, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV} !== 13'd0)
      $display("FAIL reset_values: got %b want 0",
               {Ack0, Ack1, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV});
    tick;
    RESET = 1'b0;
  endtask

  task automatic test_single;
    int n;
    Req0 = 1; InA0 = 5'd4; InB0 = 5'd3; Ctl0 = ALU_ADD;
    @(negedge CLK);
    checks++;
    if ({Ack0, Ack1, Rsp_Valid} !== 3'b100) begin
      errors++; $display("FAIL single_ack: got %b want 100", {Ack0, Ack1, Rsp_Valid});
    end
    tick; Req0 = 0;
    @(negedge CLK);
    checks++;
    if ({Ack0, Rsp_Valid} !== 2'b00) begin
      errors++; $display("FAIL single_exec: got %b want 00", {Ack0, Rsp_Valid});
    end
    tick; @(negedge CLK);
    checks++;
    if ({Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV} !== {1'b1, 1'b0, 5'd7, 4'b0000}) begin
      errors++; $display("FAIL single_rsp: got %b want %b",
        {Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV}, {1'b1, 1'b0, 5'd7, 4'b0000});
    end
    tick; @(negedge CLK);
    checks++;
    if (Rsp_Valid !== 1'b0) begin
      errors++; $display("FAIL single_drop: got %b want 0", Rsp_Valid);
    end
    tick;
  endtask

  task automatic test_tie;
    int n;
    logic [1:0] exp_ack;
    logic [5:0] exp_rsp;
    RESET = 1; tick; RESET = 0;
    Req0 = 1; InA0 = 5'd1;  InB0 = 5'd1; Ctl0 = ALU_ADD;
    Req1 = 1; InA1 = 5'd10; InB1 = 5'd3; Ctl1 = ALU_SUB;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      exp_ack = ((k % 2) == 1) ? 2'b01 : 2'b10;
      exp_rsp = ((k % 2) == 1) ? {1'b1, 5'd7} : {1'b0, 5'd2};
      n = 0;
      while (!(Ack0 | Ack1) && n < 5) begin
        tick; @(negedge CLK); n++;
      end
      checks++;
      if ({Ack0, Ack1} !== exp_ack) begin
        errors++; $display("FAIL tie_grant[%0d]: got %b want %b", k, {Ack0, Ack1}, exp_ack);
      end
      tick;
      if (k == 3) begin Req0 = 0; Req1 = 0; end
      @(negedge CLK);
      checks++;
      if ({Ack0, Ack1} !== 2'b00) begin
        errors++; $display("FAIL tie_ack_pulse[%0d]: got %b want 00", k, {Ack0, Ack1});
      end
      n = 0;
      while (!Rsp_Valid && n < 5) begin
        tick; @(negedge CLK); n++;
      end
      checks++;
      if (n !== 1) begin
        errors++; $display("FAIL tie_latency[%0d]: got %0d want 1", k, n);
      end
      checks++;
      if ({Rsp_Id, Rsp_Result} !== exp_rsp) begin
        errors++; $display("FAIL tie_rsp[%0d]: got %b want %b", k, {Rsp_Id, Rsp_Result}, exp_rsp);
      end
    end
    tick;
  endtask

  task automatic test_backpressure;
    int n;
    int exp_n;
    exp_n = FAST ? 0 : 1;
    Rsp_Ready = 0; Req0 = 0;
    Req1 = 1; InA1 = 5'd5; InB1 = 5'd5; Ctl1 = ALU_SUB;
    @(negedge CLK);
    checks++;
    if ({Ack0, Ack1} !== 2'b01) begin
      errors++; $display("FAIL bp_ack1: got %b want 01", {Ack0, Ack1});
    end
    tick;
    Req1 = 0; Req0 = 1; InA0 = 5'd9; InB0 = 5'd1; Ctl0 = ALU_ADD;
    tick;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV, Ack0} !== {1'b1, 1'b1, 5'd0, 4'b0110, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b want %b", i,
          {Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV, Ack0}, {1'b1, 1'b1, 5'd0, 4'b0110, 1'b0});
      end
      tick;
    end
    Rsp_Ready = 1;
    @(negedge CLK);
    n = 0;
    while (!Ack0 && n < 5) begin
      tick; @(negedge CLK); n++;
    end
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL bp_regrant_delay: got %0d want %0d", n, exp_n);
    end
    checks++;
    if ({Ack0, Ack1} !== 2'b10) begin
      errors++; $display("FAIL bp_regrant: got %b want 10", {Ack0, Ack1});
    end
    tick; Req0 = 0;
    n = 0;
    while (!Rsp_Valid && n < 5) begin
      @(negedge CLK);
      if (!Rsp_Valid) begin tick; n++; end
    end
    checks++;
    if ({Rsp_Id, Rsp_Result, Rsp_NZCV} !== {1'b0, 5'd10, 4'b0000}) begin
      errors++; $display("FAIL bp_rsp0: got %b want %b",
        {Rsp_Id, Rsp_Result, Rsp_NZCV}, {1'b0, 5'd10, 4'b0000});
    end
    tick;
  endtask

  task automatic test_withdraw;
    Req1 = 1; InA1 = 5'd3; InB1 = 5'd2; Ctl1 = ALU_ADD;
    @(negedge CLK);
    checks++;
    if (Ack1 !== 1'b1) begin
      errors++; $display("FAIL wd_ack1: got %b want 1", Ack1);
    end
    tick; Req1 = 0; Req0 = 1; InA0 = 5'd1; InB0 = 5'd1;
    @(negedge CLK);
    checks++;
    if (Ack0 !== 1'b0) begin
      errors++; $display("FAIL wd_no_ack_exec: got %b want 0", Ack0);
    end
    tick; Req0 = 0;
    @(negedge CLK);
    checks++;
    if ({Rsp_Valid, Rsp_Id, Rsp_Result} !== {1'b1, 1'b1, 5'd5}) begin
      errors++; $display("FAIL wd_rsp1: got %b want %b", {Rsp_Valid, Rsp_Id, Rsp_Result}, {1'b1, 1'b1, 5'd5});
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({Rsp_Valid, Ack0} !== 2'b00) begin
        errors++; $display("FAIL wd_quiet[%0d]: got %b want 00", i, {Rsp_Valid, Ack0});
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    Req0 = 1; InA0 = 5'd7; InB0 = 5'd7; Ctl0 = ALU_ADD;
    @(negedge CLK);
    checks++;
    if (Ack0 !== 1'b1) begin
      errors++; $display("FAIL rm_ack0: got %b want 1", Ack0);
    end
    tick; Req0 = 0;
    #2 RESET = 1;
    #1;
    checks++;
    if ({Ack0, Ack1, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV} !== 13'd0) begin
      errors++; $display("FAIL rm_async_clear: got %b want 0",
        {Ack0, Ack1, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_NZCV});
    end
    tick; tick;
    @(negedge CLK);
    checks++;
    if (Rsp_Valid !== 1'b0) begin
      errors++; $display("FAIL rm_no_rsp: got %b want 0", Rsp_Valid);
    end
    tick;
    RESET = 0;
    Req0 = 1; InA0 = 5'd2; InB0 = 5'd2; Ctl0 = ALU_ADD;
    Req1 = 1; InA1 = 5'd9; InB1 = 5'd9; Ctl1 = ALU_ADD;
    @(negedge CLK);
    checks++;
    if ({Ack0, Ack1} !== 2'b10) begin
      errors++; $display("FAIL rm_first_tie: got %b want 10", {Ack0, Ack1});
    end
    tick; Req0 = 0; Req1 = 0;
    wait_valid(n);
    checks++;
    if ({Rsp_Valid, Rsp_Id, Rsp_Result} !== {1'b1, 1'b0, 5'd4}) begin
      errors++; $display("FAIL rm_rsp: got %b want %b", {Rsp_Valid, Rsp_Id, Rsp_Result}, {1'b1, 1'b0, 5'd4});
    end
    tick;
  endtask

  task automatic test_ctl_codes;
    int n;
    logic [W-1:0] exp_res [8];
    logic [3:0]   exp_f   [8];
    exp_res = '{5'd18, 5'd6, 5'd4, 5'd14, 5'd10, 5'd17, 5'd0, 5'd12};
    exp_f   = '{4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0000};
    for (int c = 0; c < 8; c++) begin
      Req1 = 1; InA1 = 5'd12; InB1 = 5'd6; Ctl1 = 3'(c);
      tick; Req1 = 0;
      wait_valid(n);
      checks++;
      if ({Rsp_Valid, Rsp_Result, Rsp_NZCV} !== {1'b1, exp_res[c], exp_f[c]}) begin
        errors++; $display("FAIL ctl_code[%0d]: got %b want %b", c,
          {Rsp_Valid, Rsp_Result, Rsp_NZCV}, {1'b1, exp_res[c], exp_f[c]});
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int t_ack [4];
    int cnt;
    int exp_gap;
    exp_gap = FAST ? 2 : 3;
    cnt = 0;
    Req0 = 1; InA0 = 5'd1; InB0 = 5'd2; Ctl0 = ALU_ADD; Rsp_Ready = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      if (Ack0 && cnt < 4) begin
        t_ack[cnt] = cyc;
        cnt++;
      end
      tick;
    end
    Req0 = 0;
    checks++;
    if (cnt !== 4) begin
      errors++; $display("FAIL b2b_ack_count: got %0d want 4", cnt);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (t_ack[i] - t_ack[i-1] !== exp_gap) begin
          errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, t_ack[i] - t_ack[i-1], exp_gap);
        end
      end
    end
    repeat (4) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_backpressure;
    test_withdraw;
    test_reset_mid;
    test_ctl_codes;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
